// File: rtl/branch_predictor_if.sv
// -----------------------------------------------------------------------------
// branch_predictor_if
//
// Bundles every non-clock/reset signal of the branch predictor. There are three
// groups: the FD lookup, the X-stage training, and the statistics readout.
//
// Modports:
//   master : pipeline side. It drives the enable, lookup, update and clear
//            signals, and it receives the prediction and the statistics.
//   slave  : predictor side. It has the opposite directions.
//
// Signals:
//   bp_enable    predictor enable
//   fd_valid     FD instruction is a conditional branch
//   pc_fd        PC of the FD instruction
//   pred_taken   combinational prediction for the FD branch
//   pred_idx     table index used for the prediction (carried to X)
//   upd_valid    X instruction is a conditional branch
//   upd_idx      pred_idx carried with the X branch
//   upd_taken    resolved direction of the X branch
//   upd_pred     prediction carried with the X branch
//   cnt_clr      synchronous clear of the statistics counters
//   num_branches resolved-branch count
//   num_mispred  mispredict count
// -----------------------------------------------------------------------------
interface branch_predictor_if #(
   parameter int IDX_BITS = 5,
   parameter int CNT_W    = 32
);
   logic                bp_enable;
   logic                fd_valid;
   logic [31:0]         pc_fd;
   logic                pred_taken;
   logic [IDX_BITS-1:0] pred_idx;
   logic                upd_valid;
   logic [IDX_BITS-1:0] upd_idx;
   logic                upd_taken;
   logic                upd_pred;
   logic                cnt_clr;
   logic [CNT_W-1:0]    num_branches;
   logic [CNT_W-1:0]    num_mispred;

   modport master (
      output bp_enable, fd_valid, pc_fd, upd_valid, upd_idx, upd_taken,
             upd_pred, cnt_clr,
      input  pred_taken, pred_idx, num_branches, num_mispred
   );

   modport slave (
      input  bp_enable, fd_valid, pc_fd, upd_valid, upd_idx, upd_taken,
             upd_pred, cnt_clr,
      output pred_taken, pred_idx, num_branches, num_mispred
   );
endinterface

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// This is the dynamic branch direction predictor for the FD stage. It holds a
// table of 2-bit saturating counters:
//   00 = strong not-taken
//   01 = weak not-taken
//   10 = weak taken
//   11 = strong taken
// The table is indexed by the word-aligned PC bits. The branch resolved in X
// trains the entry through the index that was carried down the pipeline. Two
// statistics counters count resolved branches and mispredicts.
//
// Optional feature, macro BP_GSHARE_EN:
//   Enables gshare indexing. An IDX_BITS-bit global history register is
//   XORed into the lookup index.
//
// Ports:
//   clk   core clock; all state changes on the rising edge
//   rst_n asynchronous, active-low reset
//   bp    branch_predictor_if.slave, which carries:
//         - the lookup signals
//         - the update signals
//         - the statistics signals
// -----------------------------------------------------------------------------
module branch_predictor #(
   parameter int IDX_BITS = 5,
   parameter int CNT_W    = 32
) (
   input logic               clk,
   input logic               rst_n,
   branch_predictor_if.slave bp
);

   localparam int ENTRIES = 1 << IDX_BITS;

   logic [1:0]          ctr_table [ENTRIES];
   logic [IDX_BITS-1:0] pc_idx;
   logic [IDX_BITS-1:0] lookup_idx;
   logic                upd_en;
   logic [1:0]          upd_cur;
   logic [1:0]          upd_next;
   logic [CNT_W-1:0]    branch_cnt;
   logic [CNT_W-1:0]    mispred_cnt;
   logic                unused_pc_bits;

   assign pc_idx         = bp.pc_fd[IDX_BITS+1:2];
   assign unused_pc_bits = ^{bp.pc_fd[31:IDX_BITS+2], bp.pc_fd[1:0]};
   assign upd_en         = bp.upd_valid & bp.bp_enable;

`ifdef BP_GSHARE_EN
   logic [IDX_BITS-1:0] ghr;

   // The history shifts in each trained outcome. A lookup in the same cycle
   // still sees the pre-shift value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ghr <= '0;
      end else if (upd_en) begin
         ghr <= {ghr[IDX_BITS-2:0], bp.upd_taken};
      end
   end

   assign lookup_idx = pc_idx ^ ghr;
`else
   assign lookup_idx = pc_idx;
`endif

   // The lookup reads the table directly. There is no bypass from a
   // same-cycle update, so a colliding lookup returns the old counter value.
   assign bp.pred_idx   = lookup_idx;
   assign bp.pred_taken = bp.bp_enable & bp.fd_valid & ctr_table[lookup_idx][1];

   // This computes the saturating next value for the entry being trained.
   always_comb begin
      upd_cur  = ctr_table[bp.upd_idx];
      upd_next = upd_cur;
      if (bp.upd_taken) begin
         if (upd_cur != 2'b11) begin
            upd_next = upd_cur + 2'd1;
         end
      end else begin
         if (upd_cur != 2'b00) begin
            upd_next = upd_cur - 2'd1;
         end
      end
   end

   // Reset sets every entry to weak not-taken. Training always uses the
   // carried index, never an index recomputed from the current PC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            ctr_table[i] <= 2'b01;
         end
      end else if (upd_en) begin
         ctr_table[bp.upd_idx] <= upd_next;
      end
   end

   // The statistics count even while the predictor is disabled. A clear wins
   // over a same-cycle event, and that event is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_cnt  <= '0;
         mispred_cnt <= '0;
      end else if (bp.cnt_clr) begin
         branch_cnt  <= '0;
         mispred_cnt <= '0;
      end else if (bp.upd_valid) begin
         branch_cnt <= branch_cnt + CNT_W'(1);
         if (bp.upd_taken != bp.upd_pred) begin
            mispred_cnt <= mispred_cnt + CNT_W'(1);
         end
      end
   end

   assign bp.num_branches = branch_cnt;
   assign bp.num_mispred  = mispred_cnt;

endmodule
